// File: rtl/horiz_pixel_gen.sv
// horiz_pixel_gen: horizontal line timing (FP/SYNC/BP/VIDEO) with visible pixel coordinates,
// line/frame end pulses and a sticky vertical/horizontal alignment error flag.
module horiz_pixel_gen #(
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
) (
   input  logic       pixelClk,
   input  logic       rst,
   input  logic       vDataValid,
   output logic       hsync,
   output logic       de,
   output logic [9:0] pixelX,
   output logic [8:0] pixelY,
   output logic       lineEnd,
   output logic       frameEnd,
   output logic       alignErr
);
   localparam int M1   = H_FP > H_SYNC ? H_FP : H_SYNC;
   localparam int M2   = H_BP > H_ACTIVE ? H_BP : H_ACTIVE;
   localparam int MAXP = M1 > M2 ? M1 : M2;
   localparam int CW   = MAXP > 2 ? $clog2(MAXP) : 1;
   typedef enum logic [3:0] {FP = 4'b0001, SYNC = 4'b0010, BP = 4'b0100, VIDEO = 4'b1000} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d, last;
   logic [8:0]    pixel_y_q, pixel_y_d;
   logic          v_prev_q, align_err_q, align_err_d, at_exit;
   always_comb begin
      last = state_q == FP ? CW'(H_FP - 1) : state_q == SYNC ? CW'(H_SYNC - 1) :
             state_q == BP ? CW'(H_BP - 1) : CW'(H_ACTIVE - 1);
      at_exit = count_q == last;
      state_d = !at_exit ? state_q : state_q == FP ? SYNC : state_q == SYNC ? BP :
                state_q == BP ? VIDEO : FP;
      count_d = at_exit ? '0 : count_q + CW'(1);
      hsync = state_q != SYNC;
      de = state_q == VIDEO && vDataValid;
      pixelX = state_q == VIDEO ? 10'(count_q) : '0;
      lineEnd = de && count_q == CW'(H_ACTIVE - 1);
      frameEnd = lineEnd && pixel_y_q == 9'(V_ACTIVE - 1);
      pixel_y_d = !lineEnd ? pixel_y_q : frameEnd ? '0 : pixel_y_q + 9'd1;
      // vertical edges are only legal at line start; a fall must also land at row 0
      align_err_d = align_err_q
                  | (vDataValid != v_prev_q && !(state_q == FP && count_q == '0))
                  | (v_prev_q && !vDataValid && pixel_y_q != '0);
   end
   always_ff @(posedge pixelClk) begin
      if (!rst) begin
         state_q     <= FP;
         count_q     <= '0;
         pixel_y_q   <= '0;
         v_prev_q    <= 1'b0;
         align_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         pixel_y_q   <= pixel_y_d;
         v_prev_q    <= vDataValid;
         align_err_q <= align_err_d;
      end
   end
   assign pixelY   = pixel_y_q;
   assign alignErr = align_err_q;
endmodule

// File: doc/horiz_pixel_gen.md
HORIZ_PIXEL_GEN -- requirements
Module: horiz_pixel_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- H_FP, 16: horizontal front porch, in pixel clocks.
- H_SYNC, 96: hsync pulse width, in pixel clocks.
- H_BP, 48: horizontal back porch, in pixel clocks.
- H_ACTIVE, 640: visible pixels per line.
- V_ACTIVE, 480: visible lines per frame.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- pixelClk, input, 1: pixel clock; the only clock.
- rst, input, 1: reset, synchronous and active-low.
- vDataValid, input, 1: vertical active-window flag from the vertical timing stage, same clock.
- hsync, output, 1: horizontal sync, active-low.
- de, output, 1: display enable; high for visible pixels only.
- pixelX, output, 10: visible column, 0..H_ACTIVE-1.
- pixelY, output, 9: visible row, 0..V_ACTIVE-1.
- lineEnd, output, 1: one-cycle pulse on the last visible pixel of a visible line.
- frameEnd, output, 1: one-cycle pulse on the last visible pixel of a frame.
- alignErr, output, 1: sticky flag for vertical/horizontal misalignment.

REQ-003 The block SHALL use a single clock, pixelClk; reset rst SHALL be synchronous and active-low.

Function
REQ-004 The block SHALL implement a one-hot 4-state FSM, FP -> SYNC -> BP -> VIDEO -> FP, with a shared count register; line period = H_FP+H_SYNC+H_BP+H_ACTIVE = 800 clocks.

REQ-005 Each state SHALL last exactly its parameter in clocks: exit on count == param-1, with count cleared to 0 on exit and incremented by 1 otherwise.

REQ-006 hsync SHALL be 0 in SYNC and 1 in all other states, decoded combinationally from the current state.

REQ-007 de SHALL equal (state == VIDEO) AND vDataValid, combinationally.

REQ-008 pixelX SHALL equal count while in VIDEO and 0 otherwise; it SHALL never exceed H_ACTIVE-1.

REQ-009 pixelY SHALL be a registered row counter that increments on the clock edge ending a cycle where lineEnd = 1.

REQ-010 pixelY SHALL wrap from V_ACTIVE-1 to 0 on that same edge.

REQ-011 lineEnd SHALL be 1 exactly when state == VIDEO, count == H_ACTIVE-1 and vDataValid = 1.

REQ-012 frameEnd SHALL be 1 exactly when lineEnd = 1 and pixelY == V_ACTIVE-1.

REQ-013 When vDataValid = 0, pixelY SHALL hold, and de, lineEnd and frameEnd SHALL be 0; the horizontal FSM SHALL free-run regardless of vDataValid.

REQ-014 A registered copy of vDataValid SHALL be kept (vPrev).

REQ-015 alignErr SHALL be set on the next edge when either condition holds:
- vDataValid != vPrev while NOT (state == FP and count == 0);
- vDataValid falls (vPrev = 1, vDataValid = 0) while pixelY != 0.

REQ-016 alignErr, once set, SHALL stay 1 until reset; the FSM and counters SHALL keep running unaffected.

REQ-017 All counter arithmetic SHALL be unsigned; count SHALL be wide enough for max(param)-1 with no overflow under default parameters.

Reset
REQ-018 While rst = 0 at a pixelClk edge, the following SHALL be loaded:
- state = FP;
- count = 0;
- pixelY = 0;
- vPrev = 0;
- alignErr = 0.

REQ-019 During and immediately after reset, outputs SHALL read hsync = 1, de = 0, pixelX = 0, lineEnd = 0, frameEnd = 0.

REQ-020 Reset asserted mid-line or mid-frame SHALL abandon the current line and row with no residual pulse; the first post-reset cycle SHALL be FP with count = 0.

REQ-021 Deasserting reset on the same edge as the vertical stage's reset SHALL keep both stages line-aligned: 800-clock lines and vertical phase boundaries at multiples of 800.

Verification
REQ-022 Free-run check: reset release, vDataValid = 0 -> hsync low for clocks 16..111 of every 800-clock line, de never 1, pixelY stays 0, alignErr stays 0.

REQ-023 Active line check: vDataValid raised at a line start (FP, count 0) -> de high for clocks 160..799 of the line, pixelX 0..639 incrementing, lineEnd at clock 799, pixelY = 1 on the following cycle.

REQ-024 Full frame check: drive vDataValid high for exactly 480 lines from a line boundary ->
- frameEnd once, at pixelY = 479, pixelX = 639;
- pixelY = 0 afterwards;
- 307200 de cycles in total;
- alignErr = 0.

REQ-025 Misalignment check: vDataValid rises at FP count 5 -> alignErr = 1 on the next cycle and remains 1 for a further 2000 clocks; hsync timing unchanged.

REQ-026 Short frame check: vDataValid falls after 100 complete lines (pixelY = 100) -> alignErr = 1.

REQ-027 Reset mid-frame check: assert rst at pixelY = 200, pixelX = 300 for one clock -> next cycle shows hsync = 1, de = 0, pixelX = 0, pixelY = 0, alignErr = 0, and the next hsync low occurs 16 clocks after release.
